// File: rtl/ntt_stage_sequencer.sv
// NTT stage sequencer: walks mem_control through NUM_STAGES passes of clear / iterate / drain.
// Optional stall statistics output stall_cycles_o is present when NTT_SEQ_STALL_CNT_EN is defined.
module ntt_stage_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int ITERS_S0     = 257,
  parameter int ITERS_SN     = 85,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        dp_stall_i,
  output logic [1:0]  stage_o,
  output logic        incr_o,
  output logic        soft_reset_o,
  output logic [8:0]  iter_cnt_o,
  output logic        busy_o,
  output logic        done_o
`ifdef NTT_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles_o
`endif
);

  localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [8:0]     LAST_S0    = 9'(ITERS_S0 - 1);
  localparam logic [8:0]     LAST_SN    = 9'(ITERS_SN - 1);
  localparam logic [1:0]     LAST_STAGE = 2'(NUM_STAGES - 1);
  localparam logic [DRW-1:0] DRAIN_LAST = DRW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     stage_q, stage_d;
  logic [8:0]     iter_q, iter_d;
  logic [DRW-1:0] drain_q, drain_d;
  logic           start_acc, last_iter, drain_end, last_stage;

  assign start_acc  = (state_q == S_IDLE) && start_i;
  assign last_stage = (stage_q == LAST_STAGE);
  assign last_iter  = (iter_q == ((stage_q == 2'd0) ? LAST_S0 : LAST_SN));
  assign drain_end  = (drain_q == DRAIN_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      iter_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      iter_q  <= iter_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_CLR;
          stage_d = '0;
        end
      end
      S_CLR:   state_d = S_RUN;
      // A stalled final iteration keeps us in RUN until the incr really issues.
      S_RUN:   if (incr_o && last_iter) state_d = S_DRAIN;
      S_DRAIN: begin
        if (drain_end) begin
          if (last_stage) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLR;
            stage_d = stage_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase

    iter_d = iter_q;
    if (state_d == S_CLR) begin
      iter_d = '0;
    end else if (incr_o) begin
      iter_d = iter_q + 9'd1;
    end

    drain_d = ((state_q == S_DRAIN) && !drain_end) ? drain_q + DRW'(1) : '0;
  end

  always_comb begin
    incr_o       = (state_q == S_RUN) && !dp_stall_i;
    soft_reset_o = (state_q == S_CLR);
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
  end

  assign stage_o    = stage_q;
  assign iter_cnt_o = iter_q;

`ifdef NTT_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((state_q == S_RUN) && dp_stall_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: per-cycle schedule model built from pass lengths and stall vectors.
module tb_ntt_stage_sequencer;
  localparam int MAXC = 2000;
  localparam int NS   = 3;
  localparam int DC   = 4;

  logic       clk = 1'b0;
  logic       reset, start, dp_stall;
  logic [1:0] stage;
  logic       incr, soft_reset, busy, done;
  logic [8:0] iter_cnt;
`ifdef NTT_SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] o_scnt[MAXC];
`endif

  int total = 0;
  int bad   = 0;

  logic       start_v[MAXC], stall_v[MAXC], rst_v[MAXC];
  logic       o_incr[MAXC], o_soft[MAXC], o_busy[MAXC], o_done[MAXC];
  logic [1:0] o_stage[MAXC];
  logic [8:0] o_iter[MAXC];
  logic       e_incr[MAXC], e_soft[MAXC], e_busy[MAXC], e_done[MAXC], e_chk[MAXC];
  logic [1:0] e_stage[MAXC];
  logic [8:0] e_iter[MAXC];
  int         e_scnt[MAXC];

  ntt_stage_sequencer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .dp_stall_i   (dp_stall),
    .stage_o      (stage),
    .incr_o       (incr),
    .soft_reset_o (soft_reset),
    .iter_cnt_o   (iter_cnt),
    .busy_o       (busy),
    .done_o       (done)
`ifdef NTT_SEQ_STALL_CNT_EN
    ,
    .stall_cycles_o (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      start_v[i] = 1'b0; stall_v[i] = 1'b0; rst_v[i] = 1'b0;
    end
  endtask

  // Schedule model: each accepted start lays out CLR, LIMIT issued incrs (stalls stretch RUN), drain, done.
  task automatic build_model(input int n);
    int t, cnt, lim, sc;
    logic [8:0] last;
    for (int i = 0; i < MAXC; i++) begin
      e_incr[i] = 0; e_soft[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_chk[i] = 0;
      e_stage[i] = 0; e_iter[i] = 0; e_scnt[i] = -1;
    end
    t = 0;
    while (t < n) begin
      if (!start_v[t]) begin
        t++;
      end else begin
        t++;
        sc = 0;
        for (int p = 0; p < NS; p++) begin
          lim = (p == 0) ? 257 : 85;
          e_soft[t] = 1; e_busy[t] = 1; e_stage[t] = 2'(p);
          t++;
          cnt = 0;
          while (cnt < lim && t < MAXC - 3 * DC - 4) begin
            e_busy[t] = 1; e_stage[t] = 2'(p); e_iter[t] = 9'(cnt); e_chk[t] = 1;
            if (stall_v[t]) sc++;
            else begin e_incr[t] = 1; cnt++; end
            t++;
          end
          for (int d = 0; d < DC; d++) begin
            e_busy[t] = 1; e_stage[t] = 2'(p); e_iter[t] = 9'(lim); e_chk[t] = 1;
            t++;
          end
        end
        e_busy[t] = 1; e_done[t] = 1; e_stage[t] = 2'(NS - 1); e_scnt[t] = sc;
        t++;
      end
    end
    last = 9'd0;
    for (int i = 0; i < MAXC; i++) begin
      if (e_chk[i]) last = e_iter[i];
      else if (!e_busy[i]) begin e_iter[i] = last; e_chk[i] = 1; end
    end
  endtask

  task automatic simulate(input int n);
    reset = 1'b1; start = 1'b0; dp_stall = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < n; c++) begin
      #1;
      reset = rst_v[c]; start = start_v[c]; dp_stall = stall_v[c];
      @(negedge clk);
      o_incr[c] = incr; o_soft[c] = soft_reset; o_busy[c] = busy; o_done[c] = done;
      o_stage[c] = stage; o_iter[c] = iter_cnt;
`ifdef NTT_SEQ_STALL_CNT_EN
      o_scnt[c] = stall_cycles;
`endif
      @(posedge clk);
    end
    #1;
    start = 1'b0; dp_stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dp_stall = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, incr, soft_reset, stage, iter_cnt} !== 15'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b incr=%b soft=%b stage=%0d iter=%0d want all 0",
               busy, done, incr, soft_reset, stage, iter_cnt);
    end
    @(posedge clk); #1; reset = 1'b0; start = 1'b0; dp_stall = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_wins_start got busy=%b want 0", busy); end
  endtask

  task automatic test_nominal();
    int n_inc[3];
    int n_soft, n_done;
    clear_stim();
    start_v[0] = 1'b1;
    build_model(460);
    simulate(460);
    n_inc = '{0, 0, 0}; n_soft = 0; n_done = 0;
    for (int c = 0; c < 460; c++) begin
      total++;
      if ({o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c]} !== {e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]}) begin
        bad++;
        $display("FAIL nominal_ctl c=%0d got incr/soft/busy/done/stage=%b%b%b%b/%0d want %b%b%b%b/%0d", c,
                 o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c], e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]);
      end
      if (e_chk[c]) begin
        total++;
        if (o_iter[c] !== e_iter[c]) begin bad++; $display("FAIL nominal_iter c=%0d got %0d want %0d", c, o_iter[c], e_iter[c]); end
      end
      if (o_incr[c] === 1'b1 && o_stage[c] < 3) n_inc[o_stage[c]]++;
      if (o_soft[c] === 1'b1) n_soft++;
      if (o_done[c] === 1'b1) n_done++;
    end
    total++;
    if (n_inc[0] != 257 || n_inc[1] != 85 || n_inc[2] != 85) begin
      bad++; $display("FAIL nominal_incr_counts got %0d/%0d/%0d want 257/85/85", n_inc[0], n_inc[1], n_inc[2]);
    end
    total++;
    if (n_soft != 3 || o_soft[1] !== 1'b1 || o_soft[263] !== 1'b1 || o_soft[353] !== 1'b1) begin
      bad++; $display("FAIL nominal_soft_reset got count=%0d at1/263/353=%b%b%b want 3 111", n_soft, o_soft[1], o_soft[263], o_soft[353]);
    end
    total++;
    if (n_done != 1 || o_done[443] !== 1'b1) begin
      bad++; $display("FAIL nominal_done got count=%0d at443=%b want 1 1", n_done, o_done[443]);
    end
  endtask

  task automatic test_stall_mid();
    clear_stim();
    start_v[0] = 1'b1;
    for (int c = 10; c <= 14; c++) stall_v[c] = 1'b1;
    build_model(460);
    simulate(460);
    for (int c = 0; c < 460; c++) begin
      total++;
      if ({o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c]} !== {e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]}) begin
        bad++;
        $display("FAIL stall_mid_ctl c=%0d got incr/soft/busy/done/stage=%b%b%b%b/%0d want %b%b%b%b/%0d", c,
                 o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c], e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]);
      end
      if (e_chk[c]) begin
        total++;
        if (o_iter[c] !== e_iter[c]) begin bad++; $display("FAIL stall_mid_iter c=%0d got %0d want %0d", c, o_iter[c], e_iter[c]); end
      end
    end
    for (int c = 10; c <= 14; c++) begin
      total++;
      if (o_incr[c] !== 1'b0 || o_iter[c] !== 9'd8) begin
        bad++; $display("FAIL stall_mid_frozen c=%0d got incr=%b iter=%0d want 0 8", c, o_incr[c], o_iter[c]);
      end
    end
    total++;
    if (o_done[448] !== 1'b1 || o_done[443] !== 1'b0) begin
      bad++; $display("FAIL stall_mid_done got at443=%b at448=%b want 0 1", o_done[443], o_done[448]);
    end
  endtask

  task automatic test_stall_last();
    clear_stim();
    start_v[0] = 1'b1;
    for (int c = 258; c <= 260; c++) stall_v[c] = 1'b1;
    build_model(460);
    simulate(460);
    for (int c = 0; c < 460; c++) begin
      total++;
      if ({o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c]} !== {e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]}) begin
        bad++;
        $display("FAIL stall_last_ctl c=%0d got incr/soft/busy/done/stage=%b%b%b%b/%0d want %b%b%b%b/%0d", c,
                 o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c], e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]);
      end
      if (e_chk[c]) begin
        total++;
        if (o_iter[c] !== e_iter[c]) begin bad++; $display("FAIL stall_last_iter c=%0d got %0d want %0d", c, o_iter[c], e_iter[c]); end
      end
    end
    total++;
    if (o_iter[260] !== 9'd256 || o_incr[261] !== 1'b1 || o_incr[262] !== 1'b0 || o_iter[262] !== 9'd257) begin
      bad++; $display("FAIL stall_last_hold got iter260=%0d incr261=%b incr262=%b iter262=%0d want 256 1 0 257",
                      o_iter[260], o_incr[261], o_incr[262], o_iter[262]);
    end
    total++;
    if (o_soft[266] !== 1'b1 || o_done[446] !== 1'b1) begin
      bad++; $display("FAIL stall_last_timing got soft266=%b done446=%b want 1 1", o_soft[266], o_done[446]);
    end
  endtask

  task automatic test_restart();
    int n_done;
    clear_stim();
    start_v[0] = 1'b1; start_v[100] = 1'b1; start_v[444] = 1'b1;
    build_model(900);
    simulate(900);
    n_done = 0;
    for (int c = 0; c < 900; c++) begin
      total++;
      if ({o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c]} !== {e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]}) begin
        bad++;
        $display("FAIL restart_ctl c=%0d got incr/soft/busy/done/stage=%b%b%b%b/%0d want %b%b%b%b/%0d", c,
                 o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c], e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]);
      end
      if (e_chk[c]) begin
        total++;
        if (o_iter[c] !== e_iter[c]) begin bad++; $display("FAIL restart_iter c=%0d got %0d want %0d", c, o_iter[c], e_iter[c]); end
      end
      if (o_done[c] === 1'b1) n_done++;
    end
    total++;
    if (n_done != 2 || o_done[443] !== 1'b1 || o_busy[444] !== 1'b0 || o_soft[445] !== 1'b1 || o_done[887] !== 1'b1) begin
      bad++; $display("FAIL restart_events got done_count=%0d done443=%b busy444=%b soft445=%b done887=%b want 2 1 0 1 1",
                      n_done, o_done[443], o_busy[444], o_soft[445], o_done[887]);
    end
  endtask

  task automatic test_random(input int round);
    clear_stim();
    start_v[0] = 1'b1;
    for (int c = 1; c < 1300; c++) begin
      stall_v[c] = ($urandom_range(0, 99) < 20);
      if (c < 600) start_v[c] = ($urandom_range(0, 39) == 0);
    end
    build_model(1300);
    simulate(1300);
    for (int c = 0; c < 1300; c++) begin
      total++;
      if ({o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c]} !== {e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]}) begin
        bad++;
        $display("FAIL random%0d_ctl c=%0d got incr/soft/busy/done/stage=%b%b%b%b/%0d want %b%b%b%b/%0d", round, c,
                 o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c], e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]);
      end
      if (e_chk[c]) begin
        total++;
        if (o_iter[c] !== e_iter[c]) begin bad++; $display("FAIL random%0d_iter c=%0d got %0d want %0d", round, c, o_iter[c], e_iter[c]); end
      end
`ifdef NTT_SEQ_STALL_CNT_EN
      if (e_scnt[c] >= 0) begin
        total++;
        if (o_scnt[c] !== 16'(e_scnt[c])) begin
          bad++; $display("FAIL random%0d_stall_cycles c=%0d got %0d want %0d", round, c, o_scnt[c], e_scnt[c]);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    start_v[0] = 1'b1;
    rst_v[300] = 1'b1;
    build_model(500);
    simulate(500);
    for (int c = 0; c <= 300; c++) begin
      total++;
      if ({o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c]} !== {e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]}) begin
        bad++;
        $display("FAIL reset_mid_ctl c=%0d got incr/soft/busy/done/stage=%b%b%b%b/%0d want %b%b%b%b/%0d", c,
                 o_incr[c], o_soft[c], o_busy[c], o_done[c], o_stage[c], e_incr[c], e_soft[c], e_busy[c], e_done[c], e_stage[c]);
      end
    end
    total++;
    if ({o_busy[301], o_stage[301], o_incr[301], o_iter[301], o_soft[301], o_done[301]} !== 15'd0) begin
      bad++; $display("FAIL reset_mid_state got busy=%b stage=%0d incr=%b iter=%0d soft=%b done=%b want all 0",
                      o_busy[301], o_stage[301], o_incr[301], o_iter[301], o_soft[301], o_done[301]);
    end
    for (int c = 301; c < 500; c++) begin
      total++;
      if (o_done[c] !== 1'b0 || o_busy[c] !== 1'b0) begin
        bad++; $display("FAIL reset_mid_quiet c=%0d got done=%b busy=%b want 0 0", c, o_done[c], o_busy[c]);
      end
    end
  endtask

`ifdef NTT_SEQ_STALL_CNT_EN
  task automatic test_stall_count();
    clear_stim();
    start_v[0] = 1'b1; start_v[460] = 1'b1;
    for (int c = 20; c <= 23; c++) stall_v[c] = 1'b1;
    for (int c = 300; c <= 302; c++) stall_v[c] = 1'b1;
    stall_v[1] = 1'b1; stall_v[260] = 1'b1;
    simulate(470);
    total++;
    if (o_done[450] !== 1'b1 || o_scnt[450] !== 16'd7) begin
      bad++; $display("FAIL stall_count_done got done450=%b stall_cycles=%0d want 1 7", o_done[450], o_scnt[450]);
    end
    total++;
    if (o_scnt[459] !== 16'd7) begin bad++; $display("FAIL stall_count_hold got %0d want 7", o_scnt[459]); end
    total++;
    if (o_scnt[461] !== 16'd0) begin bad++; $display("FAIL stall_count_clear got %0d want 0", o_scnt[461]); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; dp_stall = 1'b0;
    test_reset();
    test_nominal();
    test_stall_mid();
    test_stall_last();
    test_restart();
    test_random(0);
    test_random(1);
    test_reset_mid();
`ifdef NTT_SEQ_STALL_CNT_EN
    test_stall_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
